nrf_spi_master: RTL and testbench

- Byte-oriented SPI master, mode 0 (CPOL=0, CPHA=0), directly downstream of the nRF24L01 command sequencer.
- Consumes the sequencer's TX byte and valid pulse, the TX ready/RX valid handshake, and its chip-select request.
- Drives the radio's SCK, MOSI and CSN pins and returns each received MISO byte.
- Owns CSN timing: setup before the first SCK edge, hold after the last, and no release mid-byte.

---
 rtl/nrf_spi_master.sv | 106 ++++++++++
 tb/tb_nrf_spi_master.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrf_spi_master.sv
// nrf_spi_master: mode-0 SPI byte master for the nRF24L01 that owns CSN setup/hold timing; defining SPI_BYTE_COUNT_EN adds o_Byte_Count
module nrf_spi_master #(
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int CS_SETUP_CLKS = 2,
  parameter int CS_HOLD_CLKS = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_DV,
  input  logic       i_SPI_Csn,
  output logic       o_SPI_Clk,
  output logic       o_SPI_MOSI,
  input  logic       i_SPI_MISO,
  output logic       o_SPI_CSn
`ifdef SPI_BYTE_COUNT_EN
  ,
  output logic [7:0] o_Byte_Count
`endif
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, HOLD = 2'd3;
  logic [1:0] state;
  logic [15:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] tx_sh, rx_sh;
  logic half_done, accept, done;
  assign half_done = cnt == 16'(CLKS_PER_HALF_BIT - 1);
  assign accept = state == IDLE && i_TX_DV && o_TX_Ready;
  assign done = state == SHIFT && half_done && o_SPI_Clk && bit_cnt == 3'd7;
  assign o_SPI_MOSI = tx_sh[7];
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      o_TX_Ready <= 1'b0;
      o_RX_Byte <= '0;
      o_RX_DV <= 1'b0;
      o_SPI_Clk <= 1'b0;
      o_SPI_CSn <= 1'b1;
    end else begin
      o_RX_DV <= 1'b0;
      case (state)
        IDLE:
          if (accept) begin
            tx_sh <= i_TX_Byte;
            o_TX_Ready <= 1'b0;
            cnt <= '0;
            bit_cnt <= '0;
            o_SPI_CSn <= 1'b0;
            state <= o_SPI_CSn ? SETUP : SHIFT;
          end else if (!o_SPI_CSn && i_SPI_Csn) begin
            o_TX_Ready <= 1'b0;
            cnt <= 16'd1;
            state <= HOLD;
          end else
            o_TX_Ready <= 1'b1;
        SETUP:
          if (cnt == 16'(CS_SETUP_CLKS - 1)) begin
            cnt <= '0;
            state <= SHIFT;
          end else
            cnt <= cnt + 16'd1;
        SHIFT:
          if (half_done) begin
            cnt <= '0;
            o_SPI_Clk <= !o_SPI_Clk;
            if (!o_SPI_Clk)
              rx_sh <= {rx_sh[6:0], i_SPI_MISO};
            else begin
              tx_sh <= {tx_sh[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
            end
            if (done) begin
              o_RX_Byte <= rx_sh;
              o_RX_DV <= 1'b1;
              o_TX_Ready <= 1'b1;
              state <= IDLE;
            end
          end else
            cnt <= cnt + 16'd1;
        HOLD:
          if (cnt >= 16'(CS_HOLD_CLKS - 1)) begin
            o_SPI_CSn <= 1'b1;
            state <= IDLE;
          end else
            cnt <= cnt + 16'd1;
      endcase
    end
  end
`ifdef SPI_BYTE_COUNT_EN
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L)
      o_Byte_Count <= '0;
    else if (accept && o_SPI_CSn)
      o_Byte_Count <= '0;
    else if (done && o_Byte_Count != 8'hFF)
      o_Byte_Count <= o_Byte_Count + 8'd1;
  end
`endif
endmodule

// File: tb/tb_nrf_spi_master.sv
// tb_nrf_spi_master: scoreboard bench for nrf_spi_master with a mode-0 MISO slave model
module tb_nrf_spi_master;
  logic i_Clk = 1'b0;
  logic i_Rst_L = 1'b0;
  logic [7:0] i_TX_Byte = 8'h00;
  logic i_TX_DV = 1'b0;
  logic i_SPI_Csn = 1'b1;
  logic o_TX_Ready, o_RX_DV, o_SPI_Clk, o_SPI_MOSI, o_SPI_CSn;
  logic [7:0] o_RX_Byte;
  logic i_SPI_MISO;
`ifdef SPI_BYTE_COUNT_EN
  logic [7:0] byte_count;
`endif
  logic [7:0] slave_sh = 8'h00;
  logic [7:0] mosi_sh = 8'h00;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  int checks = 0, errors = 0;
  int cyc = 0, rx_cnt = 0, rx_cyc = -1, acc_cyc = 0;
  int first_rise_cyc = -1, rise_cnt = 0, fall_cyc = -1;
  int csn_fall_cyc = -1, csn_rise_cyc = -1, csn_falls = 0, csn_rises = 0;
  logic prev_csn = 1'b1, prev_sck = 1'b0;

  nrf_spi_master #(.CLKS_PER_HALF_BIT(2), .CS_SETUP_CLKS(2), .CS_HOLD_CLKS(2)) dut (
    .i_Clk(i_Clk),
`ifdef SPI_BYTE_COUNT_EN
    .o_Byte_Count(byte_count),
`endif
    .i_Rst_L(i_Rst_L),
    .i_TX_Byte(i_TX_Byte),
    .i_TX_DV(i_TX_DV),
    .o_TX_Ready(o_TX_Ready),
    .o_RX_Byte(o_RX_Byte),
    .o_RX_DV(o_RX_DV),
    .i_SPI_Csn(i_SPI_Csn),
    .o_SPI_Clk(o_SPI_Clk),
    .o_SPI_MOSI(o_SPI_MOSI),
    .i_SPI_MISO(i_SPI_MISO),
    .o_SPI_CSn(o_SPI_CSn)
  );

  always #5 i_Clk = ~i_Clk;

  assign i_SPI_MISO = slave_sh[7];
  always @(negedge o_SPI_Clk) slave_sh = {slave_sh[6:0], 1'b0};
  always @(posedge o_SPI_Clk) mosi_sh = {mosi_sh[6:0], o_SPI_MOSI};

  always @(posedge i_Clk) begin
    logic [7:0] er, et;
    #1;
    cyc++;
    if (prev_csn && !o_SPI_CSn) begin csn_fall_cyc = cyc; csn_falls++; end
    if (!prev_csn && o_SPI_CSn) begin csn_rise_cyc = cyc; csn_rises++; end
    if (!prev_sck && o_SPI_Clk) begin
      rise_cnt++;
      if (first_rise_cyc < 0) first_rise_cyc = cyc;
    end
    if (prev_sck && !o_SPI_Clk) fall_cyc = cyc;
    prev_csn = o_SPI_CSn;
    prev_sck = o_SPI_Clk;
    if (o_RX_DV === 1'b1) begin
      rx_cnt++;
      rx_cyc = cyc;
      checks++;
      if (o_TX_Ready !== 1'b1) begin errors++; $display("FAIL rx_ready: o_TX_Ready=%b want 1", o_TX_Ready); end
      checks++;
      if (exp_rx.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: o_RX_DV=1 with byte %h, want no pulse", o_RX_Byte);
      end else begin
        er = exp_rx.pop_front();
        et = exp_tx.pop_front();
        checks++;
        if (o_RX_Byte !== er) begin errors++; $display("FAIL rx_byte: got %h want %h", o_RX_Byte, er); end
        if (mosi_sh !== et) begin errors++; $display("FAIL mosi_byte: got %h want %h", mosi_sh, et); end
      end
    end
  end

  task automatic send(input logic [7:0] tx, input logic [7:0] rx, input bit track);
    int t = 0;
    while (o_TX_Ready !== 1'b1 && t < 100) begin @(negedge i_Clk); t++; end
    checks++;
    if (o_TX_Ready !== 1'b1) begin errors++; $display("FAIL send_ready: o_TX_Ready=%b want 1", o_TX_Ready); end
    i_TX_Byte = tx;
    i_TX_DV = 1'b1;
    slave_sh = rx;
    if (track) begin exp_tx.push_back(tx); exp_rx.push_back(rx); end
    acc_cyc = cyc + 1;
    first_rise_cyc = -1;
    rise_cnt = 0;
    @(negedge i_Clk);
    i_TX_DV = 1'b0;
  endtask

  task automatic wait_rx(input int n0);
    int t = 0;
    while (rx_cnt == n0 && t < 200) begin @(negedge i_Clk); t++; end
    checks++;
    if (rx_cnt == n0) begin errors++; $display("FAIL rx_timeout: rx count %0d want %0d", rx_cnt, n0 + 1); end
  endtask

  task automatic wait_rises(input int n);
    int t = 0;
    while (rise_cnt < n && t < 200) begin @(negedge i_Clk); t++; end
    checks++;
    if (rise_cnt < n) begin errors++; $display("FAIL rise_timeout: rises %0d want %0d", rise_cnt, n); end
  endtask

  task automatic close_frame();
    int t = 0;
    i_SPI_Csn = 1'b1;
    while (o_SPI_CSn !== 1'b1 && t < 50) begin @(negedge i_Clk); t++; end
    checks++;
    if (o_SPI_CSn !== 1'b1) begin errors++; $display("FAIL csn_release: o_SPI_CSn=%b want 1", o_SPI_CSn); end
  endtask

  task automatic test_reset();
    i_Rst_L = 1'b0;
    repeat (3) @(negedge i_Clk);
    checks += 6;
    if (o_SPI_CSn !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b want 1", o_SPI_CSn); end
    if (o_SPI_Clk !== 1'b0) begin errors++; $display("FAIL reset_sck: got %b want 0", o_SPI_Clk); end
    if (o_SPI_MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", o_SPI_MOSI); end
    if (o_RX_Byte !== 8'h00) begin errors++; $display("FAIL reset_rx_byte: got %h want 00", o_RX_Byte); end
    if (o_RX_DV !== 1'b0) begin errors++; $display("FAIL reset_rx_dv: got %b want 0", o_RX_DV); end
    if (o_TX_Ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", o_TX_Ready); end
    i_Rst_L = 1'b1;
    @(negedge i_Clk);
    checks++;
    if (o_TX_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready_release: got %b want 1", o_TX_Ready); end
  endtask

  task automatic test_single();
    int n0 = rx_cnt;
    i_SPI_Csn = 1'b0;
    send(8'h27, 8'h0E, 1'b1);
    wait_rx(n0);
    checks += 4;
    if (csn_fall_cyc != acc_cyc) begin errors++; $display("FAIL single_csn_fall: cycle %0d want %0d", csn_fall_cyc, acc_cyc); end
    if (first_rise_cyc != acc_cyc + 4) begin errors++; $display("FAIL single_first_rise: cycle %0d want %0d", first_rise_cyc, acc_cyc + 4); end
    if (rx_cyc != acc_cyc + 34) begin errors++; $display("FAIL single_rx_time: cycle %0d want %0d", rx_cyc, acc_cyc + 34); end
    if (rx_cnt != n0 + 1) begin errors++; $display("FAIL single_rx_count: got %0d want %0d", rx_cnt, n0 + 1); end
    close_frame();
  endtask

  task automatic test_multi();
    int n0 = rx_cnt;
    int f0 = csn_falls;
    int r0 = csn_rises;
    i_SPI_Csn = 1'b0;
    send(8'h61, 8'h0E, 1'b1);
    wait_rx(n0);
    checks++;
    if (o_SPI_Clk !== 1'b0) begin errors++; $display("FAIL multi_sck_gap: got %b want 0", o_SPI_Clk); end
    send(8'hFF, 8'hA5, 1'b1);
    wait_rx(n0 + 1);
    checks += 3;
    if (first_rise_cyc != acc_cyc + 2) begin errors++; $display("FAIL multi_no_setup: first rise %0d want %0d", first_rise_cyc, acc_cyc + 2); end
    if (csn_falls != f0 + 1) begin errors++; $display("FAIL multi_csn_falls: got %0d want %0d", csn_falls, f0 + 1); end
    if (csn_rises != r0) begin errors++; $display("FAIL multi_csn_glitch: rises %0d want %0d", csn_rises, r0); end
    close_frame();
  endtask

  task automatic test_release();
    int n0 = rx_cnt;
    int t = 0;
    i_SPI_Csn = 1'b0;
    send(8'h17, 8'h3C, 1'b1);
    wait_rises(4);
    i_SPI_Csn = 1'b1;
    wait_rx(n0);
    checks += 2;
    if (o_SPI_CSn !== 1'b0) begin errors++; $display("FAIL release_midbyte: o_SPI_CSn=%b want 0", o_SPI_CSn); end
    if (rise_cnt != 8) begin errors++; $display("FAIL release_bits: rises %0d want 8", rise_cnt); end
    @(negedge i_Clk);
    while (o_SPI_CSn === 1'b0 && t < 50) begin
      checks++;
      if (o_TX_Ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b want 0", o_TX_Ready); end
      @(negedge i_Clk);
      t++;
    end
    checks += 2;
    if (o_TX_Ready !== 1'b0) begin errors++; $display("FAIL hold_ready_rise: got %b want 0", o_TX_Ready); end
    if (csn_rise_cyc - fall_cyc != 2) begin errors++; $display("FAIL hold_time: %0d cycles want 2", csn_rise_cyc - fall_cyc); end
  endtask

  task automatic test_busy();
    int n0 = rx_cnt;
    int f0 = csn_falls;
    i_SPI_Csn = 1'b1;
    send(8'h55, 8'h99, 1'b1);
    wait_rises(2);
    i_TX_Byte = 8'hAA;
    i_TX_DV = 1'b1;
    @(negedge i_Clk);
    i_TX_DV = 1'b0;
    wait_rx(n0);
    close_frame();
    repeat (40) @(negedge i_Clk);
    checks += 4;
    if (rx_cnt != n0 + 1) begin errors++; $display("FAIL busy_rx_count: got %0d want %0d", rx_cnt, n0 + 1); end
    if (rise_cnt != 8) begin errors++; $display("FAIL busy_rises: got %0d want 8", rise_cnt); end
    if (csn_falls != f0 + 1) begin errors++; $display("FAIL busy_frames: got %0d want %0d", csn_falls, f0 + 1); end
    if (exp_rx.size() != 0) begin errors++; $display("FAIL busy_pending: %0d bytes outstanding want 0", exp_rx.size()); end
  endtask

  task automatic test_reset_abort();
    int n0 = rx_cnt;
    i_SPI_Csn = 1'b0;
    send(8'h5A, 8'hC3, 1'b0);
    wait_rises(5);
    i_Rst_L = 1'b0;
    @(negedge i_Clk);
    checks += 5;
    if (o_SPI_CSn !== 1'b1) begin errors++; $display("FAIL abort_csn: got %b want 1", o_SPI_CSn); end
    if (o_SPI_Clk !== 1'b0) begin errors++; $display("FAIL abort_sck: got %b want 0", o_SPI_Clk); end
    if (o_SPI_MOSI !== 1'b0) begin errors++; $display("FAIL abort_mosi: got %b want 0", o_SPI_MOSI); end
    if (o_RX_DV !== 1'b0) begin errors++; $display("FAIL abort_rx_dv: got %b want 0", o_RX_DV); end
    if (o_RX_Byte !== 8'h00) begin errors++; $display("FAIL abort_rx_byte: got %h want 00", o_RX_Byte); end
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    @(negedge i_Clk);
    checks += 2;
    if (o_TX_Ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", o_TX_Ready); end
    if (rx_cnt != n0) begin errors++; $display("FAIL abort_rx_count: got %0d want %0d", rx_cnt, n0); end
    i_SPI_Csn = 1'b1;
  endtask

`ifdef SPI_BYTE_COUNT_EN
  task automatic test_byte_count();
    int t = 0;
    i_SPI_Csn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(8'h10 + 8'(i), 8'h20 + 8'(i), 1'b1);
      wait_rx(rx_cnt);
      checks++;
      if (byte_count !== 8'(i + 1)) begin errors++; $display("FAIL count_inc: got %0d want %0d", byte_count, i + 1); end
    end
    i_SPI_Csn = 1'b1;
    while (o_SPI_CSn === 1'b0 && t < 50) begin
      @(negedge i_Clk);
      t++;
      checks++;
      if (byte_count !== 8'd3) begin errors++; $display("FAIL count_hold: got %0d want 3", byte_count); end
    end
    i_SPI_Csn = 1'b0;
    send(8'h33, 8'h44, 1'b1);
    checks++;
    if (byte_count !== 8'd0) begin errors++; $display("FAIL count_clear: got %0d want 0", byte_count); end
    wait_rx(rx_cnt);
    checks++;
    if (byte_count !== 8'd1) begin errors++; $display("FAIL count_new_frame: got %0d want 1", byte_count); end
    close_frame();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_release();
    test_busy();
    test_reset_abort();
`ifdef SPI_BYTE_COUNT_EN
    test_byte_count();
`endif
    repeat (5) @(negedge i_Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
